sound_mixer: RTL and testbench

//  Downstream of the four channel generators (pulseChannel1 and peers); feeds swDac.

---
 rtl/gb_sound_pkg.sv | 26 ++
 rtl/sound_mixer_if.sv | 28 ++
 rtl/mixer_side.sv | 66 ++++++
 rtl/sound_mixer.sv | 72 +++++++
 tb/tb_sound_mixer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/gb_sound_pkg.sv
// rtl/gb_sound_pkg.sv - shared widths, register field positions and level conversion for the sound mixer
package gb_sound_pkg;

    localparam int CH_W   = 4;
    localparam int LVL_W  = 5;
    localparam int SUM_W  = 7;
    localparam int PROD_W = 10;
    localparam int NUM_CH = 4;
    localparam int VOL_W  = 3;

    // NR51: upper nibble routes ch4..ch1 to the left, lower nibble to the right
    localparam int NR51_L_LSB = 4;
    localparam int NR51_R_LSB = 0;

    // NR50: 3-bit master volumes; bits 7 and 3 (Vin routing) are not used here
    localparam int NR50_L_LSB = 4;
    localparam int NR50_R_LSB = 0;

    // Map a 0..15 channel code to a signed -15..+15 level; a disabled DAC outputs 0
    function automatic logic [LVL_W-1:0] ch_level(input logic [CH_W-1:0] ch, input logic dac_on);
        logic signed [LVL_W:0] wide;
        wide = $signed({1'b0, ch, 1'b0}) - 6'sd15;
        return dac_on ? wide[LVL_W-1:0] : '0;
    endfunction

endpackage

// File: rtl/sound_mixer_if.sv
// rtl/sound_mixer_if.sv - mixer control inputs and stereo sample outputs
interface sound_mixer_if
    import gb_sound_pkg::*;
#(
    parameter int OUT_W = 16
);
    logic                    en;
    logic [CH_W-1:0]         ch1;
    logic [CH_W-1:0]         ch2;
    logic [CH_W-1:0]         ch3;
    logic [CH_W-1:0]         ch4;
    logic [NUM_CH-1:0]       dac_en;
    logic [7:0]              nr51;
    logic [7:0]              nr50;
    logic signed [OUT_W-1:0] left;
    logic signed [OUT_W-1:0] right;
    logic                    valid;

    modport master (
        output en, ch1, ch2, ch3, ch4, dac_en, nr51, nr50,
        input  left, right, valid
    );

    modport slave (
        input  en, ch1, ch2, ch3, ch4, dac_en, nr51, nr50,
        output left, right, valid
    );
endinterface

// File: rtl/mixer_side.sv
// rtl/mixer_side.sv - pan sum, master volume scale and window accumulator for one stereo side
module mixer_side
    import gb_sound_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         wrap,
    input  logic [NUM_CH-1:0][LVL_W-1:0] lvl,
    input  logic [NUM_CH-1:0]            pan,
    input  logic [VOL_W-1:0]             vol,
    output logic signed [OUT_W-1:0]      sample
);
    logic signed [SUM_W-1:0]         sum_d;
    logic signed [SUM_W-1:0]         sum_q;
    logic signed [VOL_W+1:0]         gain;
    logic signed [SUM_W+VOL_W+1:0]   prod_full;
    logic signed [PROD_W-1:0]        prod_q;
    logic signed [OUT_W-1:0]         acc_q;
    logic signed [OUT_W-1:0]         acc_next;
    logic                            unused_prod_msbs;

    // Sum the sign-extended levels of every channel routed to this side
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pan[i]) begin
                sum_d = sum_d + $signed({{(SUM_W-LVL_W){lvl[i][LVL_W-1]}}, lvl[i]});
            end
        end
    end

    // Gain is vol+1 (1..8); product of +-60 and 8 always fits PROD_W, so the top bits are dropped
    always_comb begin
        gain      = $signed({1'b0, {1'b0, vol} + 4'd1});
        prod_full = sum_q * gain;
        acc_next  = acc_q + $signed({{(OUT_W-PROD_W){prod_q[PROD_W-1]}}, prod_q});
    end

    assign unused_prod_msbs = ^prod_full[SUM_W+VOL_W+1:PROD_W];

    // Pipeline and window accumulator; power-down clears the pipeline but keeps the last sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            prod_q <= '0;
            acc_q  <= '0;
            sample <= '0;
        end else if (!en) begin
            sum_q  <= '0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            prod_q <= prod_full[PROD_W-1:0];
            if (wrap) begin
                sample <= acc_next;
                acc_q  <= '0;
            end else begin
                acc_q  <= acc_next;
            end
        end
    end
endmodule

// File: rtl/sound_mixer.sv
// rtl/sound_mixer.sv - four-channel stereo pan/volume mixer with box-filter decimation
module sound_mixer
    import gb_sound_pkg::*;
#(
    parameter int DECIM = 64,
    parameter int OUT_W = 10 + $clog2(DECIM)
) (
    input  logic         clk,
    input  logic         rst,
    sound_mixer_if.slave bus
);
    localparam int CNT_W = $clog2(DECIM);

    logic [NUM_CH-1:0][LVL_W-1:0] lvl;
    logic [CNT_W-1:0]             cnt;
    logic                         wrap;
    logic                         valid_q;
    logic signed [OUT_W-1:0]      left_s;
    logic signed [OUT_W-1:0]      right_s;
    logic                         unused_vin;

    // Convert each channel code to its signed DAC level
    always_comb begin
        lvl[0] = ch_level(bus.ch1, bus.dac_en[0]);
        lvl[1] = ch_level(bus.ch2, bus.dac_en[1]);
        lvl[2] = ch_level(bus.ch3, bus.dac_en[2]);
        lvl[3] = ch_level(bus.ch4, bus.dac_en[3]);
    end

    assign wrap       = (cnt == CNT_W'(DECIM - 1));
    assign unused_vin = bus.nr50[7] ^ bus.nr50[3];

    // Window position and the one-cycle strobe that follows the closing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            valid_q <= 1'b0;
        end else if (!bus.en) begin
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= wrap;
            cnt     <= wrap ? '0 : cnt + 1'b1;
        end
    end

    mixer_side #(.OUT_W(OUT_W)) u_left (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .wrap   (wrap),
        .lvl    (lvl),
        .pan    (bus.nr51[NR51_L_LSB +: NUM_CH]),
        .vol    (bus.nr50[NR50_L_LSB +: VOL_W]),
        .sample (left_s)
    );

    mixer_side #(.OUT_W(OUT_W)) u_right (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .wrap   (wrap),
        .lvl    (lvl),
        .pan    (bus.nr51[NR51_R_LSB +: NUM_CH]),
        .vol    (bus.nr50[NR50_R_LSB +: VOL_W]),
        .sample (right_s)
    );

    assign bus.left  = left_s;
    assign bus.right = right_s;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_sound_mixer.sv
// tb/tb_sound_mixer.sv - self-checking bench for sound_mixer
module tb_sound_mixer;
    localparam int DECIM = 64;
    localparam int OUT_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sound_mixer_if #(.OUT_W(OUT_W)) bus ();

    sound_mixer #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: each edge adds the pan sum seen two edges earlier times the gain seen one edge earlier
    int  m_sum_l, m_sum_r, m_prod_l, m_prod_r, m_win_l, m_win_r, m_pos;
    int  m_add_l, m_add_r;
    int  exp_l, exp_r;
    bit  exp_v;

    function automatic int pan_sum(input bit left_side);
        int s;
        int ch [4];
        ch[0] = int'(bus.ch1); ch[1] = int'(bus.ch2);
        ch[2] = int'(bus.ch3); ch[3] = int'(bus.ch4);
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.dac_en[i] && (left_side ? bus.nr51[4+i] : bus.nr51[i]))
                s += 2 * ch[i] - 15;
        end
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference updated on every edge and on async reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sum_l = 0; m_sum_r = 0; m_prod_l = 0; m_prod_r = 0;
            m_win_l = 0; m_win_r = 0; m_pos = 0;
            exp_l = 0; exp_r = 0; exp_v = 0;
        end else if (!bus.en) begin
            m_sum_l = 0; m_sum_r = 0; m_prod_l = 0; m_prod_r = 0;
            m_win_l = 0; m_win_r = 0; m_pos = 0;
            exp_v = 0;
        end else begin
            m_add_l  = m_prod_l;
            m_add_r  = m_prod_r;
            m_prod_l = m_sum_l * (int'(bus.nr50[6:4]) + 1);
            m_prod_r = m_sum_r * (int'(bus.nr50[2:0]) + 1);
            m_sum_l  = pan_sum(1'b1);
            m_sum_r  = pan_sum(1'b0);
            m_win_l += m_add_l;
            m_win_r += m_add_r;
            if (m_pos == DECIM - 1) begin
                exp_l = m_win_l; exp_r = m_win_r; exp_v = 1;
                m_win_l = 0; m_win_r = 0; m_pos = 0;
            end else begin
                exp_v = 0;
                m_pos++;
            end
        end
    end

    // Compare the DUT against the reference away from the active edge
    always @(negedge clk) begin
        check("cyc_valid", int'(bus.valid), int'(exp_v));
        check("cyc_left", int'(bus.left), exp_l);
        check("cyc_right", int'(bus.right), exp_r);
    end

    task automatic set_in(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                          input logic [3:0] c4, input logic [3:0] de, input logic [7:0] p,
                          input logic [7:0] v);
        bus.ch1 = c1; bus.ch2 = c2; bus.ch3 = c3; bus.ch4 = c4;
        bus.dac_en = de; bus.nr51 = p; bus.nr50 = v;
    endtask

    task automatic wait_valid(input string name, output int n, output int l, output int r);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.valid && n < 4 * DECIM);
        if (!bus.valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no valid expected valid within %0d cycles", name, 4 * DECIM);
        end
        l = int'(bus.left);
        r = int'(bus.right);
    endtask

    int n, l, r, held_l, held_r;

    initial begin
        rst = 1'b1;
        bus.en = 1'b1;
        set_in(4'd15, 4'd0, 4'd0, 4'd0, 4'b0001, 8'h10, 8'h70);
        #3;
        check("reset_left", int'(bus.left), 0);
        check("reset_right", int'(bus.right), 0);
        check("reset_valid", int'(bus.valid), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Setup held from reset release: two zero contributions in the first window
        wait_valid("t4", n, l, r);
        check("t4_latency", n, 64);
        check("t4_left", l, 7440);
        check("t4_right", r, 0);
        wait_valid("t1", n, l, r);
        check("t1_period", n, 64);
        check("t1_left", l, 7680);
        check("t1_right", r, 0);

        // All channels at code 0, full pan, minimum volume
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'b1111, 8'hFF, 8'h00);
        repeat (3) wait_valid("t2", n, l, r);
        check("t2_left", l, -3840);
        check("t2_right", r, -3840);

        // DACs disabled: silence whatever the other registers say
        set_in(4'd9, 4'd3, 4'd14, 4'd6, 4'b0000, 8'hA5, 8'hE3);
        repeat (3) wait_valid("t3", n, l, r);
        check("t3_left", l, 0);
        check("t3_right", r, 0);

        // Mixed pan and unequal volumes; Vin bits set and must be ignored
        set_in(4'd15, 4'd0, 4'd8, 4'd3, 4'b1111, 8'h5A, 8'hB5);
        repeat (3) wait_valid("mix", n, l, r);
        check("mix_left", l, 4096);
        check("mix_right", r, -9216);

        // Power down mid-window: outputs hold, window restarts cleanly
        set_in(4'd15, 4'd0, 4'd0, 4'd0, 4'b0001, 8'h10, 8'h70);
        repeat (2) wait_valid("t6_pre", n, l, r);
        repeat (20) @(negedge clk);
        held_l = int'(bus.left);
        held_r = int'(bus.right);
        bus.en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("t6_no_valid", int'(bus.valid), 0);
            check("t6_hold_left", int'(bus.left), held_l);
            check("t6_hold_right", int'(bus.right), held_r);
        end
        bus.en = 1'b1;
        wait_valid("t6", n, l, r);
        check("t6_latency", n, 64);
        check("t6_left", l, 7440);

        // Asynchronous reset pulse mid-window
        repeat (30) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t5_left_async", int'(bus.left), 0);
        check("t5_right_async", int'(bus.right), 0);
        check("t5_valid_async", int'(bus.valid), 0);
        @(posedge clk);
        #7 rst = 1'b0;
        wait_valid("t5", n, l, r);
        check("t5_latency", n, 64);
        check("t5_left", l, 7440);
        check("t5_right", r, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
